// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - elastic pipeline register with 2-entry skid buffer, flush and bubble
// Optional statistics counters: define PIPE_STAGE_STATS_EN.
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 22
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              bubble,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
`ifdef PIPE_STAGE_STATS_EN
    output logic [15:0]       stall_cnt,
    output logic [15:0]       squash_cnt,
`endif
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q, state_n;
    logic [DATA_W-1:0] main_data_q, main_data_n, skid_data_q, skid_data_n;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_n, skid_ctrl_q, skid_ctrl_n;
    logic [CTRL_W-1:0] in_ctrl_eff;
    logic              acc, tak;

    assign in_ready  = (state_q != FULL) & ~flush;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;
    assign occupancy = 2'(state_q);

    assign acc         = in_valid & in_ready;
    assign tak         = out_valid & out_ready;
    assign in_ctrl_eff = bubble ? {CTRL_W{1'b0}} : in_ctrl;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_n;
            main_data_q <= main_data_n;
            main_ctrl_q <= main_ctrl_n;
            skid_data_q <= skid_data_n;
            skid_ctrl_q <= skid_ctrl_n;
        end
    end

    // Vacated entries are zeroed so unused storage never reads stale data.
    always_comb begin
        state_n     = state_q;
        main_data_n = main_data_q;
        main_ctrl_n = main_ctrl_q;
        skid_data_n = skid_data_q;
        skid_ctrl_n = skid_ctrl_q;
        if (flush) begin
            state_n     = EMPTY;
            main_data_n = '0;
            main_ctrl_n = '0;
            skid_data_n = '0;
            skid_ctrl_n = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_n     = ONE;
                        main_data_n = in_data;
                        main_ctrl_n = in_ctrl_eff;
                    end
                end
                ONE: begin
                    if (acc && tak) begin
                        main_data_n = in_data;
                        main_ctrl_n = in_ctrl_eff;
                    end else if (acc) begin
                        state_n     = FULL;
                        skid_data_n = in_data;
                        skid_ctrl_n = in_ctrl_eff;
                    end else if (tak) begin
                        state_n     = EMPTY;
                        main_data_n = '0;
                        main_ctrl_n = '0;
                    end
                end
                FULL: begin
                    if (tak) begin
                        state_n     = ONE;
                        main_data_n = skid_data_q;
                        main_ctrl_n = skid_ctrl_q;
                        skid_data_n = '0;
                        skid_ctrl_n = '0;
                    end
                end
                default: begin
                    state_n     = EMPTY;
                    main_data_n = '0;
                    main_ctrl_n = '0;
                    skid_data_n = '0;
                    skid_ctrl_n = '0;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    // A word leaving downstream in the flush cycle is delivered, not squashed.
    logic [1:0]  squash_add;
    logic [16:0] squash_sum;

    always_comb begin
        squash_add = occupancy - {1'b0, tak};
        squash_sum = {1'b0, squash_cnt} + {15'b0, squash_add};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt  <= '0;
            squash_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (flush)
                squash_cnt <= squash_sum[16] ? 16'hFFFF : squash_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - scoreboard testbench for pipe_stage_skid
// Statistics checks are compiled in when PIPE_STAGE_STATS_EN is defined.
module tb_pipe_stage_skid;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 22;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic              bubble = 1'b0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;
`ifdef PIPE_STAGE_STATS_EN
    logic [15:0]       stall_cnt;
    logic [15:0]       squash_cnt;
`endif

    int assertions = 0;
    int failures   = 0;
    logic [DATA_W+CTRL_W-1:0] sb[$];

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .bubble    (bubble),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
`ifdef PIPE_STAGE_STATS_EN
        .stall_cnt (stall_cnt),
        .squash_cnt(squash_cnt),
`endif
        .occupancy (occupancy)
    );

    // Scoreboard: inputs are stable between edges, so sample mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                assertions++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: got data=%h ctrl=%h, required no output", out_data, out_ctrl);
                end else begin
                    logic [DATA_W+CTRL_W-1:0] exp;
                    exp = sb.pop_front();
                    if ({out_data, out_ctrl} !== exp) begin
                        failures++;
                        $display("FAIL sb_order: got data=%h ctrl=%h, required data=%h ctrl=%h",
                                 out_data, out_ctrl, exp[DATA_W+CTRL_W-1:CTRL_W], exp[CTRL_W-1:0]);
                    end
                end
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready)
                sb.push_back({in_data, bubble ? {CTRL_W{1'b0}} : in_ctrl});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                         input logic b, input logic f, input logic r);
        in_valid = v; in_data = d; in_ctrl = c; bubble = b; flush = f; out_ready = r;
    endtask

    task automatic test_reset();
        tick();
        assertions++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1 || out_data !== '0) begin
            failures++;
            $display("FAIL reset_state: valid=%b occ=%0d rdy=%b data=%h, required 0 0 1 0",
                     out_valid, occupancy, in_ready, out_data);
        end
        reset = 1'b1;
        drive(1, 32'h1234_5678, 22'h2AAAA, 0, 0, 0);
        tick();
        drive(1, 32'h9ABC_DEF0, 22'h15555, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        assertions++;
        if (occupancy !== 2'd2) begin
            failures++;
            $display("FAIL reset_prefill: occ=%0d, required 2", occupancy);
        end
        reset = 1'b0;
        #1;
        assertions++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1 || out_data !== '0 || out_ctrl !== '0) begin
            failures++;
            $display("FAIL reset_midstream: valid=%b occ=%0d rdy=%b data=%h ctrl=%h, required 0 0 1 0 0",
                     out_valid, occupancy, in_ready, out_data, out_ctrl);
        end
`ifdef PIPE_STAGE_STATS_EN
        assertions++;
        if (stall_cnt !== 16'd0 || squash_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_counters: stall=%h squash=%h, required 0 0", stall_cnt, squash_cnt);
        end
`endif
        @(negedge clk);
        tick();
        reset = 1'b1;
    endtask

    task automatic test_stream();
        logic [DATA_W-1:0] words [3];
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
        for (int i = 0; i < 3; i++) begin
            drive(1, words[i], 22'(i + 1), 0, 0, 1);
            tick();
            assertions++;
            if (occupancy !== 2'd1 || out_valid !== 1'b1 || out_data !== words[i]) begin
                failures++;
                $display("FAIL stream_%0d: occ=%0d valid=%b data=%h, required 1 1 %h",
                         i, occupancy, out_valid, out_data, words[i]);
            end
        end
        drive(0, 0, 0, 0, 0, 1);
        tick();
        assertions++;
        if (occupancy !== 2'd0 || out_data !== '0) begin
            failures++;
            $display("FAIL stream_drain: occ=%0d data=%h, required 0 0", occupancy, out_data);
        end
    endtask

    task automatic test_skid();
        drive(1, 32'hA, 22'h1, 0, 0, 0);
        tick();
        drive(1, 32'hB, 22'h2, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        assertions++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA) begin
            failures++;
            $display("FAIL skid_full: occ=%0d rdy=%b data=%h, required 2 0 a", occupancy, in_ready, out_data);
        end
        drive(1, 32'hC, 22'h3, 0, 0, 0);
        tick();
        assertions++;
        if (occupancy !== 2'd2 || out_data !== 32'hA) begin
            failures++;
            $display("FAIL skid_hold: occ=%0d data=%h, required 2 a", occupancy, out_data);
        end
        drive(0, 0, 0, 0, 0, 1);
        tick();
        assertions++;
        if (occupancy !== 2'd1 || out_data !== 32'hB || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL skid_second: occ=%0d data=%h rdy=%b, required 1 b 1", occupancy, out_data, in_ready);
        end
        tick();
        assertions++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL skid_empty: occ=%0d valid=%b, required 0 0", occupancy, out_valid);
        end
    endtask

    task automatic test_bubble();
        drive(1, 32'hCAFE_0001, 22'h3FFFFF, 1, 0, 0);
        tick();
        assertions++;
        if (out_ctrl !== '0 || out_data !== 32'hCAFE_0001) begin
            failures++;
            $display("FAIL bubble_nop: ctrl=%h data=%h, required 0 cafe0001", out_ctrl, out_data);
        end
        drive(1, 32'hCAFE_0002, 22'h155555, 0, 0, 1);
        tick();
        drive(0, 0, 22'h3FFFFF, 1, 0, 0);
        tick();
        assertions++;
        if (out_ctrl !== 22'h155555 || out_data !== 32'hCAFE_0002) begin
            failures++;
            $display("FAIL bubble_idle: ctrl=%h data=%h, required 155555 cafe0002", out_ctrl, out_data);
        end
        drive(0, 0, 0, 0, 0, 1);
        tick();
    endtask

    task automatic test_flush();
        logic [15:0] sq0;
        drive(1, 32'h51, 22'h1, 0, 0, 0);
        tick();
        drive(1, 32'h52, 22'h2, 0, 0, 0);
        tick();
`ifdef PIPE_STAGE_STATS_EN
        sq0 = squash_cnt;
`else
        sq0 = 16'd0;
`endif
        drive(1, 32'hDEAD, 22'h3, 0, 1, 0);
        #1;
        assertions++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_ready: rdy=%b, required 0", in_ready);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        assertions++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== '0) begin
            failures++;
            $display("FAIL flush_full: occ=%0d valid=%b data=%h, required 0 0 0", occupancy, out_valid, out_data);
        end
`ifdef PIPE_STAGE_STATS_EN
        assertions++;
        if (squash_cnt !== sq0 + 16'd2) begin
            failures++;
            $display("FAIL squash_two: got %0d, required %0d", squash_cnt, sq0 + 16'd2);
        end
`endif
        drive(1, 32'h61, 22'h1, 0, 0, 0);
        tick();
`ifdef PIPE_STAGE_STATS_EN
        sq0 = squash_cnt;
`endif
        drive(0, 0, 0, 0, 1, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        assertions++;
        if (occupancy !== 2'd0) begin
            failures++;
            $display("FAIL flush_one: occ=%0d, required 0", occupancy);
        end
`ifdef PIPE_STAGE_STATS_EN
        assertions++;
        if (squash_cnt !== sq0) begin
            failures++;
            $display("FAIL squash_taken: got %0d, required %0d", squash_cnt, sq0);
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 22'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 2) != 0));
            tick();
        end
        drive(0, 0, 0, 0, 0, 1);
        repeat (4) tick();
        assertions++;
        if (occupancy !== 2'd0 || sb.size() != 0) begin
            failures++;
            $display("FAIL random_drain: occ=%0d pending=%0d, required 0 0", occupancy, sb.size());
        end
    endtask

`ifdef PIPE_STAGE_STATS_EN
    task automatic test_stall();
        drive(1, 32'h77, 22'h7, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        repeat (70000) @(posedge clk);
        #1;
        assertions++;
        if (stall_cnt !== 16'hFFFF) begin
            failures++;
            $display("FAIL stall_saturate: got %h, required ffff", stall_cnt);
        end
        drive(0, 0, 0, 0, 0, 1);
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_bubble();
        test_flush();
        test_random();
`ifdef PIPE_STAGE_STATS_EN
        test_stall();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
